// File: rtl/cpu_controller.sv
// -----------------------------------------------------------------------------
// cpu_controller
//
// Eight-phase instruction sequencer for a small accumulator CPU. A registered
// state machine walks phases 0..7 once per instruction. A decoder turns the
// current phase, opcode and zero flag into the datapath control strobes. A HLT
// instruction parks the machine in a HALTED state until reset.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   opcode  in   [2:0] opcode from the instruction register (valid from phase 3)
//   zero    in   accumulator-is-zero flag; only consulted in ALU_OP
//   phase   out  [2:0] current phase number (frozen at 4 while halted)
//   sel     out  address mux select: 1 = PC, 0 = IR operand
//   rd      out  memory read enable
//   ld_ir   out  instruction register load
//   inc_pc  out  program counter increment
//   ld_pc   out  program counter load (jump)
//   halt    out  processor halted
//   data_e  out  accumulator drives data bus
//   ld_ac   out  accumulator load
//   wr      out  memory write
// -----------------------------------------------------------------------------
module cpu_controller (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] opcode,
   input  logic       zero,
   output logic [2:0] phase,
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       inc_pc,
   output logic       ld_pc,
   output logic       halt,
   output logic       data_e,
   output logic       ld_ac,
   output logic       wr
);

   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_SKZ = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LDA = 3'd5;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   // Phases 0..7 use their own number as encoding so the phase output is a
   // plain slice; HALTED sits outside that range.
   typedef enum logic [3:0] {
      INST_ADDR  = 4'd0,
      INST_FETCH = 4'd1,
      INST_LOAD  = 4'd2,
      IDLE       = 4'd3,
      OP_ADDR    = 4'd4,
      OP_FETCH   = 4'd5,
      ALU_OP     = 4'd6,
      STORE      = 4'd7,
      HALTED     = 4'd8
   } state_t;

   state_t state_reg;
   state_t state_next;

   // Cleared by reset; holds the machine in INST_ADDR for the first edge after
   // reset release so a new run always gets one full extra address cycle.
   logic   run_reg;

   logic   alu_op;

   assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= INST_ADDR;
         run_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         run_reg   <= 1'b1;
      end
   end

   // Next state: a straight count with one branch point, the HLT test in
   // OP_ADDR. Opcode is ignored everywhere else.
   always_comb begin
      state_next = state_reg;
      if (run_reg) begin
         case (state_reg)
            INST_ADDR:  state_next = INST_FETCH;
            INST_FETCH: state_next = INST_LOAD;
            INST_LOAD:  state_next = IDLE;
            IDLE:       state_next = OP_ADDR;
            OP_ADDR: begin
               if (opcode == OP_HLT) state_next = HALTED;
               else                  state_next = OP_FETCH;
            end
            OP_FETCH:   state_next = ALU_OP;
            ALU_OP:     state_next = STORE;
            STORE:      state_next = INST_ADDR;
            HALTED:     state_next = HALTED;
            default:    state_next = INST_ADDR;
         endcase
      end
   end

   // Output decode. Strobes are also gated by rst_n so they drop the instant
   // reset asserts, independent of the clock.
   always_comb begin
      phase  = (state_reg == HALTED) ? 3'd4 : state_reg[2:0];
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      halt   = 1'b0;
      data_e = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;

      case (state_reg)
         INST_ADDR: begin
            sel = 1'b1;
         end
         INST_FETCH: begin
            sel = 1'b1;
            rd  = 1'b1;
         end
         INST_LOAD, IDLE: begin
            sel   = 1'b1;
            rd    = 1'b1;
            ld_ir = 1'b1;
         end
         OP_ADDR: begin
            inc_pc = (opcode != OP_HLT);
            halt   = (opcode == OP_HLT);
         end
         OP_FETCH: begin
            rd = alu_op;
         end
         ALU_OP: begin
            rd     = alu_op;
            // Skip: second PC increment only when the accumulator is zero.
            inc_pc = (opcode == OP_SKZ) && zero;
            ld_pc  = (opcode == OP_JMP);
            data_e = (opcode == OP_STO);
         end
         STORE: begin
            rd     = alu_op;
            ld_ac  = alu_op;
            ld_pc  = (opcode == OP_JMP);
            data_e = (opcode == OP_STO);
            wr     = (opcode == OP_STO);
         end
         HALTED: begin
            halt = 1'b1;
         end
         default: begin
         end
      endcase

      if (!rst_n) begin
         phase  = 3'd0;
         sel    = 1'b0;
         rd     = 1'b0;
         ld_ir  = 1'b0;
         inc_pc = 1'b0;
         ld_pc  = 1'b0;
         halt   = 1'b0;
         data_e = 1'b0;
         ld_ac  = 1'b0;
         wr     = 1'b0;
      end
   end

endmodule

// File: tb/tb_cpu_controller.sv
// -----------------------------------------------------------------------------
// tb_cpu_controller
//
// Directed bench for cpu_controller. A table of per-cycle records
// {opcode, zero, expected phase, expected strobes} is walked one clock at a
// time. Hand-written sequences cover the halted state, reset release and an
// asynchronous reset during a store.
// Strobe vector order: {sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr}
// -----------------------------------------------------------------------------
module tb_cpu_controller;

   logic       clk;
   logic       rst_n;
   logic [2:0] opcode;
   logic       zero;
   logic [2:0] phase;
   logic       sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [2:0] op;
      logic       z;
      logic [2:0] ph;
      logic [8:0] outs;
   } vec_t;

   vec_t vecs[$];

   cpu_controller dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .opcode (opcode),
      .zero   (zero),
      .phase  (phase),
      .sel    (sel),
      .rd     (rd),
      .ld_ir  (ld_ir),
      .inc_pc (inc_pc),
      .ld_pc  (ld_pc),
      .halt   (halt),
      .data_e (data_e),
      .ld_ac  (ld_ac),
      .wr     (wr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [11:0] observed();
      return {phase, sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr};
   endfunction

   task automatic check(input string name, input logic [11:0] exp);
      logic [11:0] got;
      got = observed();
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got phase=%0d strobes=%b, required phase=%0d strobes=%b",
                  name, got[11:9], got[8:0], exp[11:9], exp[8:0]);
      end
   endtask

   task automatic add(input logic [2:0] op, input logic z,
                      input logic [2:0] ph, input logic [8:0] outs);
      vec_t v;
      v.op = op; v.z = z; v.ph = ph; v.outs = outs;
      vecs.push_back(v);
   endtask

   // Apply vectors lo..hi, one per clock; inputs change on the falling edge
   // and outputs are compared 1 ns later.
   task automatic run_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         @(negedge clk);
         opcode = vecs[i].op;
         zero   = vecs[i].z;
         #1;
         check($sformatf("vec%0d op%0d ph%0d", i, vecs[i].op, vecs[i].ph),
               {vecs[i].ph, vecs[i].outs});
         $display("vec %0d: op=%0d zero=%0d phase=%0d strobes=%b", i,
                  vecs[i].op, vecs[i].z, phase,
                  {sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr});
      end
   endtask

   // Assert reset mid-cycle, check the reset state, then release and consume
   // the hold edge so the DUT sits in phase 0 ready for the next vector.
   task automatic reset_dut(input string name);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check(name, {3'd0, 9'b000000000});
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
   endtask

   initial begin
      rst_n  = 1'b0;
      opcode = 3'd0;
      zero   = 1'b0;

      // ADD, zero=0                                    idx 0..7
      add(3'd2, 1'b0, 3'd0, 9'b100000000);
      add(3'd2, 1'b0, 3'd1, 9'b110000000);
      add(3'd2, 1'b0, 3'd2, 9'b111000000);
      add(3'd2, 1'b0, 3'd3, 9'b111000000);
      add(3'd2, 1'b0, 3'd4, 9'b000100000);
      add(3'd2, 1'b0, 3'd5, 9'b010000000);
      add(3'd2, 1'b0, 3'd6, 9'b010000000);
      add(3'd2, 1'b0, 3'd7, 9'b010000010);
      // STO                                             idx 8..15
      add(3'd6, 1'b0, 3'd0, 9'b100000000);
      add(3'd6, 1'b0, 3'd1, 9'b110000000);
      add(3'd6, 1'b0, 3'd2, 9'b111000000);
      add(3'd6, 1'b0, 3'd3, 9'b111000000);
      add(3'd6, 1'b0, 3'd4, 9'b000100000);
      add(3'd6, 1'b0, 3'd5, 9'b000000000);
      add(3'd6, 1'b0, 3'd6, 9'b000000100);
      add(3'd6, 1'b0, 3'd7, 9'b000000101);
      // SKZ, zero=1                                     idx 16..23
      add(3'd1, 1'b1, 3'd0, 9'b100000000);
      add(3'd1, 1'b1, 3'd1, 9'b110000000);
      add(3'd1, 1'b1, 3'd2, 9'b111000000);
      add(3'd1, 1'b1, 3'd3, 9'b111000000);
      add(3'd1, 1'b1, 3'd4, 9'b000100000);
      add(3'd1, 1'b1, 3'd5, 9'b000000000);
      add(3'd1, 1'b1, 3'd6, 9'b000100000);
      add(3'd1, 1'b1, 3'd7, 9'b000000000);
      // SKZ, zero=0, zero pulsed high only in phase 5   idx 24..31
      add(3'd1, 1'b0, 3'd0, 9'b100000000);
      add(3'd1, 1'b0, 3'd1, 9'b110000000);
      add(3'd1, 1'b0, 3'd2, 9'b111000000);
      add(3'd1, 1'b0, 3'd3, 9'b111000000);
      add(3'd1, 1'b0, 3'd4, 9'b000100000);
      add(3'd1, 1'b1, 3'd5, 9'b000000000);
      add(3'd1, 1'b0, 3'd6, 9'b000000000);
      add(3'd1, 1'b0, 3'd7, 9'b000000000);
      // JMP                                             idx 32..39
      add(3'd7, 1'b0, 3'd0, 9'b100000000);
      add(3'd7, 1'b0, 3'd1, 9'b110000000);
      add(3'd7, 1'b0, 3'd2, 9'b111000000);
      add(3'd7, 1'b0, 3'd3, 9'b111000000);
      add(3'd7, 1'b0, 3'd4, 9'b000100000);
      add(3'd7, 1'b0, 3'd5, 9'b000000000);
      add(3'd7, 1'b0, 3'd6, 9'b000010000);
      add(3'd7, 1'b0, 3'd7, 9'b000010000);
      // XOR, zero=1 (zero irrelevant)                   idx 40..47
      add(3'd4, 1'b1, 3'd0, 9'b100000000);
      add(3'd4, 1'b1, 3'd1, 9'b110000000);
      add(3'd4, 1'b1, 3'd2, 9'b111000000);
      add(3'd4, 1'b1, 3'd3, 9'b111000000);
      add(3'd4, 1'b1, 3'd4, 9'b000100000);
      add(3'd4, 1'b1, 3'd5, 9'b010000000);
      add(3'd4, 1'b1, 3'd6, 9'b010000000);
      add(3'd4, 1'b1, 3'd7, 9'b010000010);
      // HLT up to the halting phase                     idx 48..52
      add(3'd0, 1'b0, 3'd0, 9'b100000000);
      add(3'd0, 1'b0, 3'd1, 9'b110000000);
      add(3'd0, 1'b0, 3'd2, 9'b111000000);
      add(3'd0, 1'b0, 3'd3, 9'b111000000);
      add(3'd0, 1'b0, 3'd4, 9'b000001000);

      // Reset state with clock running
      #12;
      check("reset_initial", {3'd0, 9'b000000000});
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);   // hold edge: DUT must stay in phase 0

      // Back-to-back instructions straight from reset
      run_range(0, 52);

      // Halted: phase frozen at 4, only halt asserted, inputs ignored
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         opcode = 3'($urandom_range(0, 7));
         zero   = 1'($urandom_range(0, 1));
         #1;
         check($sformatf("halted_cycle%0d", c), {3'd4, 9'b000001000});
         $display("halted %0d: op=%0d zero=%0d phase=%0d halt=%0d", c, opcode, zero, phase, halt);
      end

      // Reset pulse leaves HALTED; then a fresh ADD runs from phase 0
      reset_dut("halt_reset");
      run_range(0, 7);

      // Asynchronous reset in phase 6 of a STO: strobes drop without an edge
      run_range(8, 14);
      #2;
      rst_n = 1'b0;
      #1;
      check("sto_async_reset", {3'd0, 9'b000000000});
      $display("async reset in STO: phase=%0d data_e=%0d wr=%0d", phase, data_e, wr);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      run_range(8, 15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 The block SHALL have these ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  3  opcode field from the instruction register; valid from phase 3 onward
- zero  input  1  accumulator-is-zero flag from the ALU
- phase  output  3  current sequencer state encoding, 0..7
- sel  output  1  address mux select: 1 = PC address, 0 = IR operand address
- rd  output  1  memory read enable
- ld_ir  output  1  instruction register load enable
- inc_pc  output  1  program counter increment enable
- ld_pc  output  1  program counter load enable (jump)
- halt  output  1  processor halted indication
- data_e  output  1  data bus drive enable (accumulator to memory)
- ld_ac  output  1  accumulator load enable
- wr  output  1  memory write enable

REQ-002 The opcodes SHALL be:
- HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP SHALL mean opcode in {ADD, AND, XOR, LDA}.

Function
REQ-003 The block SHALL contain a registered state machine with these states:
- INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7, HALTED (distinct internal encoding).
REQ-004 In states 0..7, the state SHALL advance by one each clk, and STORE SHALL wrap to INST_ADDR.
REQ-005 In OP_ADDR with opcode==HLT, the next state SHALL be HALTED.
REQ-006 HALTED SHALL be absorbing and left only by reset.
REQ-007 The phase output SHALL equal the state number for states 0..7, and SHALL equal 4 in HALTED (frozen).
REQ-008 Outputs SHALL be combinational decodes of the current state, opcode and zero. Any output not listed for a state SHALL be 0.
- INST_ADDR: sel=1
- INST_FETCH: sel=1, rd=1
- INST_LOAD: sel=1, rd=1, ld_ir=1
- IDLE: sel=1, rd=1, ld_ir=1
- OP_ADDR: inc_pc=(opcode!=HLT), halt=(opcode==HLT)
- OP_FETCH: rd=ALUOP
- ALU_OP: rd=ALUOP, inc_pc=(opcode==SKZ && zero), ld_pc=(opcode==JMP), data_e=(opcode==STO)
- STORE: rd=ALUOP, ld_ac=ALUOP, ld_pc=(opcode==JMP), data_e=(opcode==STO), wr=(opcode==STO)
- HALTED: halt=1 only
REQ-009 The zero input SHALL be evaluated only in ALU_OP; zero changes in other states SHALL have no effect.
REQ-010 wr SHALL be asserted for exactly one cycle per STO instruction, and only while data_e=1.
REQ-011 inc_pc and ld_pc SHALL never both be 1 in the same cycle.
REQ-012 Each non-halting instruction SHALL take exactly 8 clk cycles.
REQ-013 Each non-halting instruction SHALL produce exactly one inc_pc pulse, plus a second one for SKZ with zero=1.
REQ-014 Opcode changes outside IDLE..STORE SHALL NOT alter state transitions, except the HLT check in OP_ADDR.

Reset
REQ-015 rst_n=0 SHALL immediately force the state to INST_ADDR and phase=0, with no clock required.
REQ-016 While rst_n=0, all other outputs (sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr) SHALL be 0.
REQ-017 On the first rising clk edge after rst_n deasserts, the state SHALL remain INST_ADDR (sel=1). Advancing to INST_FETCH SHALL occur on the following edge.
REQ-018 Reset asserted mid-instruction or in HALTED SHALL abort or exit immediately to the REQ-015 condition.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- ADD, zero=0, run 8 cycles from reset -> phase 0..7; rd=1 in phases 1,2,3,5,6,7; ld_ir in phases 2,3; inc_pc only in phase 4; ld_ac only in phase 7; wr never.
- STO -> data_e=1 in phases 6,7; wr=1 only in phase 7; rd=0 in phases 5..7.
- SKZ with zero=1 -> inc_pc=1 in phases 4 and 6. Repeat with zero=0 -> inc_pc in phase 4 only. zero toggled in phase 5 has no effect.
- JMP -> ld_pc=1 in phases 6,7; inc_pc=0 in those phases; next instruction starts at phase 0.
- HLT -> halt=1 and inc_pc=0 in phase 4. Then phase stays 4, halt stays 1, and all other outputs stay 0 for 20 cycles. rst_n pulse -> phase=0, halt=0.
- rst_n asserted asynchronously in phase 6 of an STO -> wr/data_e drop to 0 without a clock edge. After release, the sequence restarts at phase 0.
